// File: rtl/deserializer8_if.sv
// Serial-in / byte-out handshake bundle for deserializer8.
// The slave modport is the deserializer's own view of the signals.
interface deserializer8_if;
  logic       s_bit;
  logic       s_sof;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       sync_err;

  modport master (
    output s_bit, s_sof, s_valid, m_ready,
    input  s_ready, m_data, m_valid, sync_err
  );

  modport slave (
    input  s_bit, s_sof, s_valid, m_ready,
    output s_ready, m_data, m_valid, sync_err
  );
endinterface

// File: rtl/deserializer8.sv
// Serial-to-byte deserializer with an output register and a one-byte hold slot.
// Bit order is LSB-first by default; define DESER8_MSB_FIRST_EN for MSB-first.
module deserializer8 (
  input  logic clk,
  input  logic rst,
  deserializer8_if.slave ser
);

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hold_q, hold_d;
  logic [7:0] out_q, out_d;
  logic       mvalid_q, mvalid_d;
  logic       err_q, err_d;

  logic       accept;
  logic       out_free;
  logic [2:0] eff_cnt;
  logic [2:0] pos;
  logic [7:0] byte_w;

  assign ser.s_ready  = ~hold_q;
  assign ser.m_data   = out_q;
  assign ser.m_valid  = mvalid_q;
  assign ser.sync_err = err_q;

  always_comb begin
    accept   = ser.s_valid & ~hold_q;
    out_free = ~mvalid_q | ser.m_ready;
    // A start-of-byte marker restarts assembly at bit 0.
    eff_cnt  = ser.s_sof ? 3'd0 : cnt_q;
`ifdef DESER8_MSB_FIRST_EN
    pos      = 3'd7 - eff_cnt;
`else
    pos      = eff_cnt;
`endif
    byte_w      = (eff_cnt == 3'd0) ? 8'h00 : shift_q;
    byte_w[pos] = ser.s_bit;

    shift_d  = shift_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    out_d    = out_q;
    mvalid_d = mvalid_q & ~ser.m_ready;
    err_d    = 1'b0;

    // Held byte moves into the output register as soon as it frees up.
    if (hold_q && out_free) begin
      out_d    = shift_q;
      mvalid_d = 1'b1;
      hold_d   = 1'b0;
    end

    if (accept) begin
      shift_d = byte_w;
      cnt_d   = eff_cnt + 3'd1;
      err_d   = ser.s_sof & (cnt_q != 3'd0);
      if (eff_cnt == 3'd7) begin
        if (out_free) begin
          out_d    = byte_w;
          mvalid_d = 1'b1;
        end else begin
          hold_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= 8'h00;
      cnt_q    <= 3'd0;
      hold_q   <= 1'b0;
      out_q    <= 8'h00;
      mvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      mvalid_q <= mvalid_d;
      err_q    <= err_d;
    end
  end

endmodule
